// File: rtl/mpc_types.sv
// Shared types for the meta lookup controller: array geometry, meta entry layout,
// lookup FSM states and the response bundle.
package mpc_types;

    localparam int SET_W     = 3;
    localparam int WAY_NUM   = 4;
    localparam int WAY_IDX_W = 2;
    localparam int TAG_W     = 20;
    localparam int META_W    = TAG_W + 2;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } meta_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CMP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } lookup_state_e;

    typedef struct packed {
        logic                 hit;
        logic [WAY_IDX_W-1:0] way;
        logic                 evict;
        logic [TAG_W-1:0]     evict_tag;
        logic                 evict_dirty;
    } lookup_rsp_t;

    function automatic logic [WAY_NUM-1:0] way_onehot(input logic [WAY_IDX_W-1:0] idx);
        logic [WAY_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/meta_victim_sel.sv
// Victim way selection: lowest-index invalid way, or the round-robin way when the set is full.
module meta_victim_sel
    import mpc_types::*;
(
    input  logic [WAY_NUM-1:0]   valid,
    input  logic [WAY_IDX_W-1:0] rr_ptr,
    output logic [WAY_NUM-1:0]   victim_oh,
    output logic [WAY_IDX_W-1:0] victim_idx,
    output logic                 all_valid
);

    always_comb begin
        all_valid  = &valid;
        victim_idx = rr_ptr;
        if (!all_valid) begin
            // Descending scan so the lowest invalid index is the last one written.
            for (int w = WAY_NUM - 1; w >= 0; w--) begin
                if (!valid[w]) victim_idx = WAY_IDX_W'(w);
            end
        end
        victim_oh = way_onehot(victim_idx);
    end

endmodule

// File: rtl/meta_lookup_ctrl.sv
// Meta array lookup controller: one tag lookup in flight, hit/miss report, victim allocation.
// Optional perf counters are built when MPC_META_LOOKUP_PERF_EN is defined.
module meta_lookup_ctrl
    import mpc_types::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SET_W-1:0]               req_set,
    input  logic [TAG_W-1:0]               req_tag,
    input  logic                           req_write,
    input  logic                           req_alloc,
    output logic                           meta_read_valid,
    input  logic                           meta_read_ready,
    output logic [SET_W-1:0]               meta_read_set,
    input  logic [WAY_NUM-1:0][META_W-1:0] meta_read_rsp,
    output logic                           meta_write_valid,
    input  logic                           meta_write_ready,
    output logic [SET_W-1:0]               meta_write_set,
    output logic [WAY_NUM-1:0]             meta_write_way_en,
    output logic [META_W-1:0]              meta_write_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_hit,
    output logic [WAY_IDX_W-1:0]           rsp_way,
    output logic                           rsp_evict,
    output logic [TAG_W-1:0]               rsp_evict_tag,
    output logic                           rsp_evict_dirty,
`ifdef MPC_META_LOOKUP_PERF_EN
    output logic [31:0]                    perf_hit_cnt,
    output logic [31:0]                    perf_miss_cnt,
    output logic [31:0]                    perf_evict_cnt,
`endif
    output lookup_state_e                  dbg_state
);

    // Every channel transfers on a cycle where valid and ready are both high; a valid
    // side holds its payload unchanged until that cycle and never withdraws early.

    lookup_state_e        state;
    logic [SET_W-1:0]     lat_set;
    logic [TAG_W-1:0]     lat_tag;
    logic                 lat_write;
    logic                 lat_alloc;
    logic                 wr_evict;
    lookup_rsp_t          rsp_q;
    logic [WAY_IDX_W-1:0] rr_ptr [1 << SET_W];

    meta_entry_t [WAY_NUM-1:0] ent;
    logic [WAY_NUM-1:0]        valid_vec;
    logic                      hit;
    logic [WAY_IDX_W-1:0]      hit_way;
    logic [WAY_NUM-1:0]        victim_oh;
    logic [WAY_IDX_W-1:0]      victim_idx;
    logic                      all_valid;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        valid_vec = '0;
        ent       = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            ent[w]       = meta_entry_t'(meta_read_rsp[w]);
            valid_vec[w] = ent[w].valid;
            if (ent[w].valid && ent[w].tag == lat_tag) begin
                hit     = 1'b1;
                hit_way = WAY_IDX_W'(w);
            end
        end
    end

    meta_victim_sel u_victim_sel (
        .valid      (valid_vec),
        .rr_ptr     (rr_ptr[lat_set]),
        .victim_oh  (victim_oh),
        .victim_idx (victim_idx),
        .all_valid  (all_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            req_ready         <= 1'b1;
            lat_set           <= '0;
            lat_tag           <= '0;
            lat_write         <= 1'b0;
            lat_alloc         <= 1'b0;
            wr_evict          <= 1'b0;
            meta_read_valid   <= 1'b0;
            meta_read_set     <= '0;
            meta_write_valid  <= 1'b0;
            meta_write_set    <= '0;
            meta_write_way_en <= '0;
            meta_write_data   <= '0;
            rsp_valid         <= 1'b0;
            rsp_q             <= '0;
            for (int s = 0; s < (1 << SET_W); s++) rr_ptr[s] <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    lat_set         <= req_set;
                    lat_tag         <= req_tag;
                    lat_write       <= req_write;
                    lat_alloc       <= req_alloc;
                    req_ready       <= 1'b0;
                    meta_read_valid <= 1'b1;
                    meta_read_set   <= req_set;
                    state           <= ST_RD;
                end
                ST_RD: if (meta_read_ready) begin
                    meta_read_valid <= 1'b0;
                    state           <= ST_CMP;
                end
                ST_CMP: begin
                    rsp_q <= '0;
                    if (hit) begin
                        rsp_q.hit <= 1'b1;
                        rsp_q.way <= hit_way;
                        if (lat_write && !ent[hit_way].dirty) begin
                            wr_evict          <= 1'b0;
                            meta_write_valid  <= 1'b1;
                            meta_write_set    <= lat_set;
                            meta_write_way_en <= way_onehot(hit_way);
                            meta_write_data   <= {1'b1, 1'b1, lat_tag};
                            state             <= ST_WR;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RSP;
                        end
                    end else if (lat_alloc) begin
                        // A victim is only ever valid when the whole set is valid.
                        rsp_q.way         <= victim_idx;
                        rsp_q.evict       <= all_valid;
                        rsp_q.evict_tag   <= all_valid ? ent[victim_idx].tag : '0;
                        rsp_q.evict_dirty <= all_valid & ent[victim_idx].dirty;
                        wr_evict          <= all_valid;
                        meta_write_valid  <= 1'b1;
                        meta_write_set    <= lat_set;
                        meta_write_way_en <= victim_oh;
                        meta_write_data   <= {1'b1, lat_write, lat_tag};
                        state             <= ST_WR;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_WR: if (meta_write_ready) begin
                    meta_write_valid  <= 1'b0;
                    meta_write_way_en <= '0;
                    meta_write_data   <= '0;
                    if (wr_evict) rr_ptr[lat_set] <= rr_ptr[lat_set] + WAY_IDX_W'(1);
                    rsp_valid         <= 1'b1;
                    state             <= ST_RSP;
                end
                ST_RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_hit         = rsp_q.hit;
    assign rsp_way         = rsp_q.way;
    assign rsp_evict       = rsp_q.evict;
    assign rsp_evict_tag   = rsp_q.evict_tag;
    assign rsp_evict_dirty = rsp_q.evict_dirty;
    assign dbg_state       = state;

`ifdef MPC_META_LOOKUP_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_cnt   <= '0;
            perf_miss_cnt  <= '0;
            perf_evict_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_q.hit && perf_hit_cnt != '1) perf_hit_cnt <= perf_hit_cnt + 32'd1;
            if (!rsp_q.hit && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
            if (rsp_q.evict && perf_evict_cnt != '1) perf_evict_cnt <= perf_evict_cnt + 32'd1;
        end
    end
`endif

endmodule
